// File: rtl/lvds_scan_ctrl.sv
// lvds_scan_ctrl - raster scan controller for the LVDS panel path.
//
// Generates horizontal/vertical timing, places a stored IMG_W x IMG_H image at
// (IMG_X0, IMG_Y0) inside the active area and drives the image RAM read port.
// Timing outputs are delayed so they line up with the RAM's 1-cycle read data.
//
// Ports:
//   clkq        in   pixel clock, all logic on the rising edge
//   rst_n       in   synchronous active-low reset
//   run         in   level, request scanning
//   addrX       out  [15:0] image RAM read address (held while en=00)
//   en          out  [1:0]  image RAM read enable, 2'b01 = read, 2'b00 = hold
//   hsync       out  horizontal sync, active high, RAM-latency aligned
//   vsync       out  vertical sync, active high, RAM-latency aligned
//   de          out  data enable (active area), RAM-latency aligned
//   img_sel     out  1 = RAM data valid this cycle, 0 = serializer drives black
//   frame_start out  1-cycle pulse with the first active pixel of each frame
//   busy        out  1 while not idle
module lvds_scan_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 80,
  parameter int V_ACTIVE = 800,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 14,
  parameter int IMG_W    = 100,
  parameter int IMG_H    = 100,
  parameter int IMG_X0   = 0,
  parameter int IMG_Y0   = 0
) (
  input  logic        clkq,
  input  logic        rst_n,
  input  logic        run,
  output logic [15:0] addrX,
  output logic [1:0]  en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        img_sel,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_WIDTH = 16'(H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_WIDTH = 16'(V_SYNC);
  localparam logic [15:0] WIN_X0   = 16'(IMG_X0);
  localparam logic [15:0] WIN_Y0   = 16'(IMG_Y0);
  localparam logic [15:0] WIN_W    = 16'(IMG_W);
  localparam logic [15:0] WIN_H    = 16'(IMG_H);
  localparam logic [15:0] PIX_LAST = 16'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [15:0] h_cnt_r;
  logic [15:0] v_cnt_r;
  logic [15:0] pix_cnt_r;

  logic running_s;
  logic last_s;
  logic act_s;
  logic win_s;
  logic hs_s;
  logic vs_s;
  logic fs_s;

  // First delay stage of the timing signals (cycle N, alongside en/addrX).
  logic hs_p1_r;
  logic vs_p1_r;
  logic de_p1_r;
  logic win_p1_r;
  logic fs_p1_r;

  // Stage 0: decode raster position into timing/window flags.
  // Range tests use wrapping subtraction, (x - start) < width, which also
  // covers start = 0 without a degenerate x >= 0 comparison.
  always_comb begin
    running_s = (state_r != ST_IDLE);
    last_s    = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
    act_s     = running_s && (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    win_s     = act_s && ((h_cnt_r - WIN_X0) < WIN_W) && ((v_cnt_r - WIN_Y0) < WIN_H);
    hs_s      = running_s && ((h_cnt_r - HS_START) < HS_WIDTH);
    vs_s      = running_s && ((v_cnt_r - VS_START) < VS_WIDTH);
    fs_s      = running_s && (h_cnt_r == 16'd0) && (v_cnt_r == 16'd0);
  end

  // Next-state logic; STOP keeps scanning so the current frame always completes.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) state_nx_s = ST_SCAN;
        else     state_nx_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (!run) state_nx_s = ST_STOP;
        else      state_nx_s = ST_SCAN;
      end
      ST_STOP: begin
        if (run)         state_nx_s = ST_SCAN;
        else if (last_s) state_nx_s = ST_IDLE;
        else             state_nx_s = ST_STOP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clkq) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Raster counters: held at 0 while idle, so scanning starts at (0,0).
  always_ff @(posedge clkq) begin
    if (!rst_n || (state_r == ST_IDLE)) begin
      h_cnt_r <= 16'd0;
      v_cnt_r <= 16'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 16'd0;
      if (v_cnt_r == V_LAST) v_cnt_r <= 16'd0;
      else                   v_cnt_r <= v_cnt_r + 16'd1;
    end else begin
      h_cnt_r <= h_cnt_r + 16'd1;
    end
  end

  // Image pixel index; advances only on visible window cycles, restarts each frame.
  always_ff @(posedge clkq) begin
    if (!rst_n || (state_r == ST_IDLE) || last_s) begin
      pix_cnt_r <= 16'd0;
    end else if (win_s) begin
      if (pix_cnt_r == PIX_LAST) pix_cnt_r <= 16'd0;
      else                       pix_cnt_r <= pix_cnt_r + 16'd1;
    end else begin
      pix_cnt_r <= pix_cnt_r;
    end
  end

  // RAM read port; the address is held between reads and cleared when idle.
  always_ff @(posedge clkq) begin
    if (!rst_n || !running_s) begin
      en    <= 2'b00;
      addrX <= 16'd0;
    end else if (win_s) begin
      en    <= 2'b01;
      addrX <= pix_cnt_r;
    end else begin
      en    <= 2'b00;
      addrX <= addrX;
    end
  end

  // Two-stage delay of the timing flags so they meet the RAM read data.
  always_ff @(posedge clkq) begin
    if (!rst_n) begin
      hs_p1_r     <= 1'b0;
      vs_p1_r     <= 1'b0;
      de_p1_r     <= 1'b0;
      win_p1_r    <= 1'b0;
      fs_p1_r     <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      img_sel     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs_p1_r     <= hs_s;
      vs_p1_r     <= vs_s;
      de_p1_r     <= act_s;
      win_p1_r    <= win_s;
      fs_p1_r     <= fs_s;
      hsync       <= hs_p1_r;
      vsync       <= vs_p1_r;
      de          <= de_p1_r;
      img_sel     <= win_p1_r;
      frame_start <= fs_p1_r;
    end
  end

  // Busy flag tracks the state register directly.
  always_ff @(posedge clkq) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= (state_nx_s != ST_IDLE);
  end

endmodule

// File: tb/tb_lvds_scan_ctrl.sv
// Directed testbench for lvds_scan_ctrl with small timing parameters:
// H 8/1/2/1 (12 clocks/line), V 6/1/1/1 (9 lines), image 4x3 at (2,1).
// A second instance places the window at X0=6 so it is clipped to h=6,7.
module tb_lvds_scan_ctrl;

  localparam int IMG_W0 = 4;
  localparam int IMG_H0 = 3;

  logic        clkq = 1'b0;
  logic        rst_n;
  logic        run;

  logic [15:0] addr0, addr1;
  logic [1:0]  en0, en1;
  logic        hs0, vs0, de0, img0, fs0, busy0;
  logic        hs1, vs1, de1, img1, fs1, busy1;

  logic [7:0]  d_outR = 8'd0;
  logic [7:0]  cap [0:63];
  int          cap_n = 0;
  int          reads0 = 0;
  int          reads1 = 0;
  int          fs_n = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clkq = ~clkq;

  lvds_scan_ctrl #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .IMG_W(IMG_W0), .IMG_H(IMG_H0), .IMG_X0(2), .IMG_Y0(1)
  ) dut0 (
    .clkq(clkq), .rst_n(rst_n), .run(run),
    .addrX(addr0), .en(en0), .hsync(hs0), .vsync(vs0), .de(de0),
    .img_sel(img0), .frame_start(fs0), .busy(busy0)
  );

  lvds_scan_ctrl #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .IMG_W(4), .IMG_H(3), .IMG_X0(6), .IMG_Y0(1)
  ) dut1 (
    .clkq(clkq), .rst_n(rst_n), .run(run),
    .addrX(addr1), .en(en1), .hsync(hs1), .vsync(vs1), .de(de1),
    .img_sel(img1), .frame_start(fs1), .busy(busy1)
  );

  // Image RAM model for dut0, preloaded so that data == address.
  always_ff @(posedge clkq) begin
    if (en0 == 2'b01) d_outR <= addr0[7:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clkq);
    #1;
  endtask

  // Window membership in raster coordinates (active area is 8x6, rows 1..3).
  function automatic bit in_win(input int h, input int v, input int x0);
    return (h < 8) && (v < 6) && (h >= x0) && (h < x0 + 4) && (v >= 1) && (v < 4);
  endfunction

  initial begin
    int te, to, h, v;
    bit ok_e, ok_o, exp_w;

    if (IMG_W0 * IMG_H0 > 65536) begin
      $display("FAIL img_size observed=%0d expected<=65536", IMG_W0 * IMG_H0);
      $fatal(1, "image does not fit the 16-bit address space");
    end

    rst_n = 1'b0;
    run   = 1'b0;
    repeat (3) step();
    check("rst_addrX", 32'(addr0), 32'd0);
    check("rst_en", 32'(en0), 32'd0);
    check("rst_hsync", 32'(hs0), 32'd0);
    check("rst_vsync", 32'(vs0), 32'd0);
    check("rst_de", 32'(de0), 32'd0);
    check("rst_img_sel", 32'(img0), 32'd0);
    check("rst_frame_start", 32'(fs0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);

    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy0), 32'd0);
    check("idle_en", 32'(en0), 32'd0);

    // Frames 1..3; run drops at (h=5,v=2) of frame 3; stage-0 cycle t valid for 0..323.
    run = 1'b1;
    for (int k = 1; k <= 330; k++) begin
      step();
      te = k - 2;
      to = k - 3;
      ok_e = (te >= 0) && (te <= 323);
      ok_o = (to >= 0) && (to <= 323);

      check("busy", 32'(busy0), {31'd0, (k <= 324)});

      h = (te < 0) ? 0 : te % 12;
      v = (te < 0) ? 0 : (te / 12) % 9;
      exp_w = ok_e && in_win(h, v, 2);
      check("en0", 32'(en0), exp_w ? 32'd1 : 32'd0);
      if (exp_w) check("addrX0", 32'(addr0), 32'((v - 1) * 4 + (h - 2)));
      exp_w = ok_e && in_win(h, v, 6);
      check("en1_clip", 32'(en1), exp_w ? 32'd1 : 32'd0);
      if (exp_w) check("addrX1_clip", 32'(addr1), 32'((v - 1) * 2 + (h - 6)));
      if (te >= 324) check("addrX0_idle", 32'(addr0), 32'd0);

      h = (to < 0) ? 0 : to % 12;
      v = (to < 0) ? 0 : (to / 12) % 9;
      check("de", 32'(de0), {31'd0, ok_o && (h < 8) && (v < 6)});
      check("hsync", 32'(hs0), {31'd0, ok_o && (h == 9 || h == 10)});
      check("vsync", 32'(vs0), {31'd0, ok_o && (v == 7)});
      check("img_sel", 32'(img0), {31'd0, ok_o && in_win(h, v, 2)});
      check("img_sel1", 32'(img1), {31'd0, ok_o && in_win(h, v, 6)});
      check("frame_start", 32'(fs0), {31'd0, ok_o && (h == 0) && (v == 0)});

      if (en0 == 2'b01) reads0++;
      if (en1 == 2'b01) reads1++;
      if (fs0) fs_n++;
      if (img0 && cap_n < 64) begin
        cap[cap_n] = d_outR;
        cap_n++;
      end

      if (k == 246) run = 1'b0;
    end

    check("reads_dut0", 32'(reads0), 32'd36);
    check("reads_dut1_clip", 32'(reads1), 32'd18);
    check("frame_starts", 32'(fs_n), 32'd3);
    check("captured_count", 32'(cap_n), 32'd36);
    for (int i = 0; i < 36; i++) check("d_outR_seq", 32'(cap[i]), 32'(i % 12));

    // Restart, then reset for one clock at (h=3,v=1).
    run = 1'b1;
    repeat (16) step();
    check("pre_rst_en", 32'(en0), 32'd1);
    check("pre_rst_addrX", 32'(addr0), 32'd0);
    rst_n = 1'b0;
    step();
    check("mid_rst_en", 32'(en0), 32'd0);
    check("mid_rst_addrX", 32'(addr0), 32'd0);
    check("mid_rst_de", 32'(de0), 32'd0);
    check("mid_rst_hsync", 32'(hs0), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_fs_1", 32'(fs0), 32'd0);
    check("post_rst_busy", 32'(busy0), 32'd1);
    step();
    check("post_rst_fs_2", 32'(fs0), 32'd0);
    step();
    check("post_rst_fs_3", 32'(fs0), 32'd1);
    repeat (12) step();
    check("post_rst_en_before", 32'(en0), 32'd0);
    step();
    check("post_rst_en_first", 32'(en0), 32'd1);
    check("post_rst_addrX_first", 32'(addr0), 32'd0);
    step();
    check("post_rst_img_sel", 32'(img0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
